// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA raster timing generator.
package vga_pkg;

  localparam int unsigned COORD_W = 10;

  // Default 640x480@60 timing
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned COLOR_W = 4;
  typedef logic [COLOR_W-1:0] color_t;

  function automatic color_t chan_fill(input logic bit_i);
    return {COLOR_W{bit_i}};
  endfunction

endpackage

// File: rtl/vga_color_bars.sv
// Eight vertical colour bars for bring-up; only built when VGA_TEST_PATTERN_EN is defined.
`ifdef VGA_TEST_PATTERN_EN
module vga_color_bars
  import vga_pkg::*;
#(
  parameter int unsigned BAR_W = H_ACTIVE_DEF / 8
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_ena,
  input  logic   i_de,
  input  logic   i_line_start,
  output color_t o_r,
  output color_t o_g,
  output color_t o_b
);

  localparam logic [COORD_W-1:0] BAR_LAST = COORD_W'(BAR_W - 1);

  logic [COORD_W-1:0] r_px;
  logic [2:0]         r_bar;
  logic [COORD_W-1:0] w_px;
  logic [2:0]         w_bar;

  // Pixel/bar position for the current cycle; line_start restarts both
  always_comb begin
    w_px  = r_px;
    w_bar = r_bar;
    if (i_line_start) begin
      w_px  = '0;
      w_bar = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_px  <= '0;
      r_bar <= '0;
      o_r   <= '0;
      o_g   <= '0;
      o_b   <= '0;
    end else if (i_ena) begin
      if (i_de && (w_px == BAR_LAST)) begin
        r_px  <= '0;
        r_bar <= w_bar + 3'd1;
      end else if (i_de) begin
        r_px  <= w_px + 1'b1;
        r_bar <= w_bar;
      end else begin
        r_px  <= w_px;
        r_bar <= w_bar;
      end
      o_r <= i_de ? chan_fill(w_bar[0]) : '0;
      o_g <= i_de ? chan_fill(w_bar[1]) : '0;
      o_b <= i_de ? chan_fill(w_bar[2]) : '0;
    end
  end

endmodule
`endif

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: registered hs/vs/de, coordinates and line/frame strobes.
// Optional colour-bar source enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  output logic               hs,
  output logic               vs,
  output logic               de,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start,
  output color_t             r,
  output color_t             g,
  output color_t             b
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT   = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT   = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEG  = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END  = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_BEG  = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END  = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [COORD_W-1:0] r_h_cnt;
  logic [COORD_W-1:0] r_v_cnt;

  logic w_de;
  logic w_hs_act;
  logic w_vs_act;
  logic w_line_start;
  logic w_frame_start;

  // Decode of the current counter position, registered below
  always_comb begin
    w_de          = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    w_hs_act      = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
    w_vs_act      = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);
    w_line_start  = (r_h_cnt == '0);
    w_frame_start = w_line_start && (r_v_cnt == '0);
  end

  // Raster position counters; h and v wrap together at the last pixel of the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (ena) begin
      if (r_h_cnt == H_LAST) begin
        r_h_cnt <= '0;
        if (r_v_cnt == V_LAST) begin
          r_v_cnt <= '0;
        end else begin
          r_v_cnt <= r_v_cnt + 1'b1;
        end
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ena) begin
      x           <= r_h_cnt;
      y           <= r_v_cnt;
      de          <= w_de;
      hs          <= w_hs_act ? HS_POL : ~HS_POL;
      vs          <= w_vs_act ? VS_POL : ~VS_POL;
      line_start  <= w_line_start;
      frame_start <= w_frame_start;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  vga_color_bars #(
    .BAR_W(H_ACTIVE / 8)
  ) u_color_bars (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_ena        (ena),
    .i_de         (w_de),
    .i_line_start (w_line_start),
    .o_r          (r),
    .o_g          (g),
    .o_b          (b)
  );
`else
  assign r = '0;
  assign g = '0;
  assign b = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: default 640x480 instance plus a scaled-down instance for whole-frame coverage.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       de;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } exp_t;

  // Hand-computed reference vectors (field order x,y,de,hs,vs,ls,fs,rgb)
  localparam exp_t RST0   = {10'd0, 10'd0, 5'b01100, 12'h000};
  localparam exp_t FIRST0 = {10'd0, 10'd0, 5'b11111, 12'h000};
  localparam exp_t RST1   = {10'd0, 10'd0, 5'b00000, 12'h000};
  localparam exp_t FIRST1 = {10'd0, 10'd0, 5'b10011, 12'h000};

  logic clk = 1'b0;
  logic rst_n;
  logic ena;

  logic       hs0, vs0, de0, ls0, fs0;
  logic [9:0] x0, y0;
  logic [3:0] r0, g0, b0;
  logic       hs1, vs1, de1, ls1, fs1;
  logic [9:0] x1, y1;
  logic [3:0] r1, g1, b1;

  exp_t act0, act1;
  assign act0 = {x0, y0, de0, hs0, vs0, ls0, fs0, r0, g0, b0};
  assign act1 = {x1, y1, de1, hs1, vs1, ls1, fs1, r1, g1, b1};

  always #5 clk = ~clk;

  vga_timing_gen u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .hs(hs0), .vs(vs0), .de(de0), .x(x0), .y(y0),
    .line_start(ls0), .frame_start(fs0), .r(r0), .g(g0), .b(b0)
  );

  // 24 x 11 raster, active-high syncs: hs on x=18..20, vs on y=7..8
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .hs(hs1), .vs(vs1), .de(de1), .x(x1), .y(y1),
    .line_start(ls1), .frame_start(fs1), .r(r1), .g(g1), .b(b1)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  exp_t q0[$];
  exp_t q1[$];
  int   h0 = 0, v0 = 0, h1 = 0, v1 = 0;
  bit   stalled = 1'b0;

  task automatic chk(input string nm, input exp_t a, input exp_t e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b rgb=%h%h%h, want x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b rgb=%h%h%h",
               nm, a.x, a.y, a.de, a.hs, a.vs, a.ls, a.fs, a.r, a.g, a.b,
               e.x, e.y, e.de, e.hs, e.vs, e.ls, e.fs, e.r, e.g, e.b);
    end
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, a, e);
    end
  endtask

  function automatic exp_t model(input int h, input int v, input int ha, input int hfp,
                                 input int hsy, input int va, input int vfp, input int vsy,
                                 input bit hp, input bit vp);
    exp_t e;
    int   k;
    e    = '0;
    e.x  = 10'(h);
    e.y  = 10'(v);
    e.de = (h < ha) && (v < va);
    e.hs = (h >= ha + hfp && h < ha + hfp + hsy) ? hp : !hp;
    e.vs = (v >= va + vfp && v < va + vfp + vsy) ? vp : !vp;
    e.ls = (h == 0);
    e.fs = (h == 0) && (v == 0);
    k    = h / (ha / 8);
`ifdef VGA_TEST_PATTERN_EN
    if (e.de) begin
      e.r = {4{k[0]}};
      e.g = {4{k[1]}};
      e.b = {4{k[2]}};
    end
`endif
    return e;
  endfunction

  // One stimulus cycle: queue the expected outputs for the coming edge when enabled
  task automatic step(input bit en);
    @(negedge clk);
    rst_n = 1'b1;
    ena   = en;
    if (en) begin
      q0.push_back(model(h0, v0, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0));
      q1.push_back(model(h1, v1, 16, 2, 3, 6, 1, 2, 1'b1, 1'b1));
      h0 = (h0 == 799) ? 0 : h0 + 1;
      if (h0 == 0) v0 = (v0 == 524) ? 0 : v0 + 1;
      h1 = (h1 == 23) ? 0 : h1 + 1;
      if (h1 == 0) v1 = (v1 == 10) ? 0 : v1 + 1;
    end
  endtask

  task automatic apply_reset(input string nm);
    @(negedge clk);
    rst_n = 1'b0;
    ena   = 1'b1;
    #1;
    chk({nm, "_std"}, act0, RST0);
    chk({nm, "_small"}, act1, RST1);
    h0 = 0; v0 = 0; h1 = 0; v1 = 0;
    repeat (2) @(negedge clk);
    #1;
    chk({nm, "_hold_std"}, act0, RST0);
    chk({nm, "_hold_small"}, act1, RST1);
  endtask

  task automatic first_edge(input string nm);
    step(1'b1);
    @(posedge clk);
    #2;
    chk({nm, "_std"}, act0, FIRST0);
    chk({nm, "_small"}, act1, FIRST1);
  endtask

  // Monitor state
  bit   en_s;
  exp_t last0, last1, e0, e1;
  int   idx = 0;
  int   ls_prev0 = -1, hs_lo0 = 0, de_n0 = 0, n_line_chk = 0;
  int   fs_prev1 = -1, vs_hi1 = 0, de_n1 = 0, n_frame_chk = 0;

  always @(posedge clk) begin
    en_s = ena && rst_n;
    #1;
    if (!rst_n) begin
      last0    = RST0;
      last1    = RST1;
      ls_prev0 = -1;
      fs_prev1 = -1;
    end else if (en_s) begin
      if (q0.size() == 0 || q1.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got q0=%0d q1=%0d entries, want at least 1", q0.size(), q1.size());
      end else begin
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        chk("trace_std", act0, e0);
        chk("trace_small", act1, e1);
        last0 = e0;
        last1 = e1;
      end
      idx++;
      if (act0.ls) begin
        if (ls_prev0 >= 0) begin
          chk_int("line_period", idx - ls_prev0, 800);
          chk_int("hs_low_per_line", hs_lo0, 96);
          chk_int("de_per_line", de_n0, 640);
          n_line_chk++;
        end
        ls_prev0 = idx;
        hs_lo0   = 0;
        de_n0    = 0;
      end
      if (!act0.hs) hs_lo0++;
      if (act0.de)  de_n0++;
      if (act1.fs) begin
        if (fs_prev1 >= 0) begin
          chk_int("frame_period_small", idx - fs_prev1, 264);
          chk_int("vs_active_per_frame_small", vs_hi1, 48);
          chk_int("de_per_frame_small", de_n1, 96);
          n_frame_chk++;
        end
        fs_prev1 = idx;
        vs_hi1   = 0;
        de_n1    = 0;
      end
      if (act1.vs) vs_hi1++;
      if (act1.de) de_n1++;
`ifdef VGA_TEST_PATTERN_EN
      if (act0.y == 10'd0) begin
        case (act0.x)
          10'd0, 10'd79, 10'd640: chk_int("bar_black", int'({act0.r, act0.g, act0.b}), 'h000);
          10'd80:                 chk_int("bar_red",   int'({act0.r, act0.g, act0.b}), 'hF00);
          10'd639:                chk_int("bar_white", int'({act0.r, act0.g, act0.b}), 'hFFF);
          default: ;
        endcase
      end
`endif
    end else begin
      chk("hold_std", act0, last0);
      chk("hold_small", act1, last1);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    ena   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_std", act0, RST0);
    chk("reset_small", act1, RST1);
    apply_reset("reset_ena_high");
    first_edge("first_edge");

    // Run ~3 lines of the default raster and ~10 small frames, stalling once at x=100
    for (int i = 0; i < 2600; i++) begin
      if (h0 == 101 && v0 == 0 && !stalled) begin
        stalled = 1'b1;
        repeat (5) step(1'b0);
      end
      step(1'b1);
    end

    apply_reset("reset_mid_frame");
    first_edge("restart_edge");
    for (int i = 0; i < 900; i++) step(1'b1);
    repeat (3) step(1'b0);

    @(negedge clk);
    chk_int("scoreboard_drained_std", q0.size(), 0);
    chk_int("scoreboard_drained_small", q1.size(), 0);
    chk_int("stall_seen", int'(stalled), 1);
    chk_int("line_checks_done", int'(n_line_chk >= 3), 1);
    chk_int("frame_checks_done", int'(n_frame_chk >= 8), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
